seg7_sequence_monitor: RTL and testbench

- Receive-side checker for the BCD display link: takes an active-low 7-segment pattern and its update strobe from GPIO.
- Decodes the pattern back to a BCD digit and verifies that digits advance 0→9→0.
- Counts sequence errors and flags a stalled link.
- Sits on the 50 MHz domain of a second board, or in loopback on the same board, as bring-up/diagnostic logic.

---
 rtl/seg7_sequence_monitor_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 33 +++
 rtl/seg7_sequence_monitor.sv | 185 ++++++++++++++++++
 tb/tb_seg7_sequence_monitor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_sequence_monitor_pkg.sv
// Shared definitions for the 7-segment receive-side checker: segment code table,
// monitor state encoding and the BCD wrap helper.
package seg7_sequence_monitor_pkg;

   // Active-low {g..a} codes, identical to the table the display encoder drives
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

   localparam logic [3:0] DIGIT_MAX = 4'd9;

   typedef enum logic {
      SEEK   = 1'b0,
      LOCKED = 1'b1
   } mon_state_t;

   function automatic logic [3:0] next_digit(input logic [3:0] d);
      return (d == DIGIT_MAX) ? 4'd0 : (d + 4'd1);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational lookup from an active-low 7-segment pattern to {valid, BCD digit}.
// Any pattern outside the ten legal codes reports valid=0 and digit 0.
module seg7_decode
   import seg7_sequence_monitor_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic       valid,
   output logic [3:0] digit
);

   // Table lookup; unknown patterns fall through to the invalid default
   always_comb begin
      valid = 1'b1;
      digit = 4'd0;
      case (seg_n)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: begin
            valid = 1'b0;
            digit = 4'd0;
         end
      endcase
   end

endmodule

// File: rtl/seg7_sequence_monitor.sv
// Receive-side checker for the BCD display link: samples the pattern on each strobe
// falling edge, checks the 0..9 wrap sequence, counts errors and flags a stalled link.
module seg7_sequence_monitor
   import seg7_sequence_monitor_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 60000000,
   parameter int LOCK_LOSS   = 3,
   parameter int ERR_W       = 8
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic [6:0]       seg_n,
   input  logic             strobe,
   input  logic             clear_err,
   output logic [3:0]       digit,
   output logic             digit_valid,
   output logic             sample_pulse,
   output logic             seq_error,
   output logic             locked,
   output logic             stalled,
   output logic [ERR_W-1:0] err_count
);

   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int MISS_W = $clog2(LOCK_LOSS + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOCK_LOSS);

   logic [SYNC_STAGES-1:0][6:0] seg_sync_r;
   logic [SYNC_STAGES-1:0]      strobe_sync_r;
   logic                        strobe_prev_r;
   logic [6:0]                  seg_synced_s;
   logic                        fall_s;
   logic                        dec_valid_s;
   logic [3:0]                  dec_digit_s;

   mon_state_t       state_r, state_next;
   logic [3:0]       expected_r, expected_next;
   logic [MISS_W-1:0] miss_r, miss_next;
   logic [CNT_W-1:0] cnt_r, cnt_next;
   logic             stalled_r, stalled_next;
   logic [ERR_W-1:0] err_count_r, err_next;
   logic [3:0]       digit_r, digit_next;
   logic             digit_valid_r, valid_next;
   logic             sample_pulse_r, pulse_next;
   logic             seq_error_r, seqerr_next;
   logic             locked_r;
   logic             err_inc_s;

   assign seg_synced_s = seg_sync_r[SYNC_STAGES-1];
   assign fall_s       = strobe_prev_r & ~strobe_sync_r[SYNC_STAGES-1];

   // Input synchronizer chains and strobe edge history
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         seg_sync_r    <= '0;
         strobe_sync_r <= '0;
         strobe_prev_r <= 1'b0;
      end else begin
         seg_sync_r    <= {seg_sync_r[SYNC_STAGES-2:0], seg_n};
         strobe_sync_r <= {strobe_sync_r[SYNC_STAGES-2:0], strobe};
         strobe_prev_r <= strobe_sync_r[SYNC_STAGES-1];
      end
   end

   seg7_decode u_decode (
      .seg_n (seg_synced_s),
      .valid (dec_valid_s),
      .digit (dec_digit_s)
   );

   // Sample processing, sequence tracking and stall timeout
   always_comb begin
      state_next    = state_r;
      expected_next = expected_r;
      miss_next     = miss_r;
      cnt_next      = cnt_r;
      stalled_next  = stalled_r;
      digit_next    = digit_r;
      valid_next    = digit_valid_r;
      pulse_next    = 1'b0;
      seqerr_next   = 1'b0;
      err_inc_s     = 1'b0;
      if (fall_s) begin
         pulse_next   = 1'b1;
         cnt_next     = '0;
         stalled_next = 1'b0;
         valid_next   = dec_valid_s;
         if (dec_valid_s) begin
            digit_next = dec_digit_s;
         end else begin
            digit_next = digit_r;
         end
         case (state_r)
            SEEK: begin
               if (dec_valid_s) begin
                  expected_next = next_digit(dec_digit_s);
                  state_next    = LOCKED;
                  miss_next     = '0;
               end else begin
                  state_next = SEEK;
               end
            end
            LOCKED: begin
               if (dec_valid_s && (dec_digit_s == expected_r)) begin
                  miss_next     = '0;
                  expected_next = next_digit(expected_r);
               end else begin
                  seqerr_next   = 1'b1;
                  err_inc_s     = 1'b1;
                  // A legal but wrong digit re-seeds; garbage keeps the old cadence
                  expected_next = dec_valid_s ? next_digit(dec_digit_s) : next_digit(expected_r);
                  if ((miss_r + MISS_W'(1)) == MISS_LIMIT) begin
                     state_next = SEEK;
                     miss_next  = '0;
                  end else begin
                     miss_next = miss_r + MISS_W'(1);
                  end
               end
            end
            default: begin
               state_next = SEEK;
               miss_next  = '0;
            end
         endcase
      end else if (cnt_r == CNT_LAST) begin
         stalled_next = 1'b1;
         state_next   = SEEK;
         miss_next    = '0;
      end else begin
         cnt_next = cnt_r + CNT_W'(1);
      end
   end

   // Saturating error counter; a clear overrides a coincident increment
   always_comb begin
      err_next = err_count_r;
      if (clear_err) begin
         err_next = '0;
      end else if (err_inc_s && (err_count_r != {ERR_W{1'b1}})) begin
         err_next = err_count_r + ERR_W'(1);
      end else begin
         err_next = err_count_r;
      end
   end

   // State and output registers
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         state_r        <= SEEK;
         expected_r     <= 4'd0;
         miss_r         <= '0;
         cnt_r          <= '0;
         stalled_r      <= 1'b0;
         err_count_r    <= '0;
         digit_r        <= 4'd0;
         digit_valid_r  <= 1'b0;
         sample_pulse_r <= 1'b0;
         seq_error_r    <= 1'b0;
         locked_r       <= 1'b0;
      end else begin
         state_r        <= state_next;
         expected_r     <= expected_next;
         miss_r         <= miss_next;
         cnt_r          <= cnt_next;
         stalled_r      <= stalled_next;
         err_count_r    <= err_next;
         digit_r        <= digit_next;
         digit_valid_r  <= valid_next;
         sample_pulse_r <= pulse_next;
         seq_error_r    <= seqerr_next;
         locked_r       <= (state_next == LOCKED);
      end
   end

   assign digit        = digit_r;
   assign digit_valid  = digit_valid_r;
   assign sample_pulse = sample_pulse_r;
   assign seq_error    = seq_error_r;
   assign locked       = locked_r;
   assign stalled      = stalled_r;
   assign err_count    = err_count_r;

endmodule

// File: tb/tb_seg7_sequence_monitor.sv
// Directed bench for seg7_sequence_monitor: lock-in, sequence errors, lock loss,
// stall timeout, error-counter saturation/clear and asynchronous reset.
module tb_seg7_sequence_monitor;

   localparam int TO = 200;

   logic       clock_in = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] seg_n = 7'h7F;
   logic       strobe = 1'b0;
   logic       clear_err = 1'b0;
   logic [3:0] digit;
   logic       digit_valid, sample_pulse, seq_error, locked, stalled;
   logic [7:0] err_count;

   int   tests = 0;
   int   failed = 0;
   int   pulse_cnt = 0;
   int   serr_cnt = 0;
   int   snap;
   logic last_se;
   logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   seg7_sequence_monitor #(
      .SYNC_STAGES (2),
      .TIMEOUT     (TO),
      .LOCK_LOSS   (3),
      .ERR_W       (8)
   ) dut (
      .clock_in     (clock_in),
      .reset        (reset),
      .seg_n        (seg_n),
      .strobe       (strobe),
      .clear_err    (clear_err),
      .digit        (digit),
      .digit_valid  (digit_valid),
      .sample_pulse (sample_pulse),
      .seq_error    (seq_error),
      .locked       (locked),
      .stalled      (stalled),
      .err_count    (err_count)
   );

   always #10 clock_in = ~clock_in;

   always @(negedge clock_in) begin
      if (sample_pulse) pulse_cnt <= pulse_cnt + 1;
      if (seq_error) serr_cnt <= serr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One strobe period; the sample must land exactly three edges after the fall
   task automatic send(input logic [6:0] code, input logic clr);
      @(posedge clock_in); #1;
      seg_n  = code;
      strobe = 1'b1;
      repeat (4) @(posedge clock_in);
      #1 strobe = 1'b0;
      @(posedge clock_in); #1;
      @(posedge clock_in); #1;
      chk("pulse_early", sample_pulse, 0);
      clear_err = clr;
      @(posedge clock_in); #1;
      clear_err = 1'b0;
      chk("pulse_latency", sample_pulse, 1);
      last_se = seq_error;
      repeat (2) @(posedge clock_in);
      #1;
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (3) @(negedge clock_in);
      chk("rst_digit", digit, 0);
      chk("rst_valid", digit_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_stalled", stalled, 0);
      chk("rst_err", err_count, 0);
      reset = 1'b1;

      // Clean 0..9,0 run
      for (int i = 0; i < 11; i++) begin
         send(codes[i % 10], 1'b0);
         chk("seq_digit", digit, i % 10);
         chk("seq_valid", digit_valid, 1);
         chk("seq_locked", locked, 1);
      end
      chk("seq_pulses", pulse_cnt, 11);
      chk("seq_no_err", serr_cnt, 0);
      chk("seq_err_count", err_count, 0);

      // Advance to 4, repeat 4, then 5
      for (int i = 1; i < 5; i++) send(codes[i], 1'b0);
      send(7'h19, 1'b0);
      chk("rep_se", last_se, 1);
      chk("rep_err", err_count, 1);
      chk("rep_locked", locked, 1);
      send(7'h12, 1'b0);
      chk("rep5_se", last_se, 0);
      chk("rep5_digit", digit, 5);
      chk("rep5_err", err_count, 1);

      // Standalone clear
      @(posedge clock_in); #1 clear_err = 1'b1;
      @(posedge clock_in); #1 clear_err = 1'b0;
      chk("clear_err", err_count, 0);

      // Three illegal codes drop lock
      for (int i = 0; i < 3; i++) begin
         send(7'h7F, 1'b0);
         chk("ill_se", last_se, 1);
         chk("ill_valid", digit_valid, 0);
         chk("ill_digit_hold", digit, 5);
         chk("ill_err", err_count, i + 1);
         chk("ill_locked", locked, (i < 2) ? 1 : 0);
      end
      send(7'h24, 1'b0);
      chk("relock", locked, 1);
      chk("relock_digit", digit, 2);
      chk("relock_se", last_se, 0);

      // Stall: sample registered 2 edges before return
      repeat (TO - 3) @(posedge clock_in);
      #1 chk("stall_before", stalled, 0);
      @(posedge clock_in);
      #1 chk("stall_at", stalled, 1);
      chk("stall_locked", locked, 0);
      chk("stall_err", err_count, 3);
      repeat (5) @(posedge clock_in);
      #1 chk("stall_hold", stalled, 1);
      send(7'h30, 1'b0);
      chk("unstall", stalled, 0);
      chk("unstall_digit", digit, 3);
      chk("unstall_locked", locked, 1);
      chk("unstall_se", last_se, 0);

      // Saturation: repeated 0 yields three errors per four samples
      for (int i = 0; i < 400; i++) send(7'h40, 1'b0);
      chk("sat_err", err_count, 255);
      send(7'h40, 1'b0);
      chk("sat_se", last_se, 1);
      chk("sat_hold", err_count, 255);
      send(7'h40, 1'b1);
      chk("clr_win_se", last_se, 1);
      chk("clr_win_err", err_count, 0);
      send(7'h79, 1'b0);
      chk("post_clr_se", last_se, 0);
      chk("post_clr_digit", digit, 1);
      send(7'h7F, 1'b0);
      chk("pre_rst_err", err_count, 1);

      // Reset with a strobe fall in flight
      @(posedge clock_in); #1;
      seg_n  = 7'h24;
      strobe = 1'b1;
      repeat (4) @(posedge clock_in);
      #1 strobe = 1'b0;
      @(posedge clock_in);
      #1 reset = 1'b0;
      #1;
      chk("arst_digit", digit, 0);
      chk("arst_locked", locked, 0);
      chk("arst_err", err_count, 0);
      chk("arst_pulse", sample_pulse, 0);
      repeat (3) @(negedge clock_in);
      reset = 1'b1;
      snap = pulse_cnt;
      repeat (8) @(posedge clock_in);
      #1 chk("lost_edge", pulse_cnt, snap);
      send(7'h30, 1'b0);
      chk("rst_relock", locked, 1);
      chk("rst_relock_digit", digit, 3);
      chk("rst_relock_err", err_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
